// File: rtl/dm_cache_controller.sv
// rtl/dm_cache_controller.sv - direct-mapped write-back write-allocate data cache controller
//
// Serves 32-bit CPU loads/stores from a LINES x WORDS internal array; on a miss
// evicts a dirty victim and refills the block one word at a time over the main
// memory read/write/done handshake.
//
// Ports:
//   clock, reset            clock, asynchronous active-high reset
//   cpu_read, cpu_write     CPU load/store request, held until cpu_done
//   cpu_addr[9:0]           byte address: tag [9:6], index [5:4], word [3:2]
//   cpu_wdata[31:0]         store data
//   cpu_rdata[31:0]         load data, valid while cpu_done
//   cpu_done                one-cycle completion pulse
//   mem_read, mem_write     word request to main memory, held until mem_done
//   mem_addr[9:0]           word-aligned memory address
//   mem_wdata[31:0]         write data to memory
//   mem_rdata[31:0]         read data from memory
//   mem_done                memory completion
module dm_cache_controller #(
  parameter int LINES = 4,
  parameter int WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [9:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        mem_read,
  output logic        mem_write,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done
);

  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(WORDS);
  localparam int TAG_W = 10 - 2 - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COMPARE   = 2'd1,
    S_WRITEBACK = 2'd2,
    S_ALLOCATE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [OFF_W-1:0]   cnt_q;
  logic [9:2]         addr_q;
  logic [31:0]        wdata_q;
  logic               wr_q;
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [31:0]        cpu_rdata_q;
  logic               cpu_done_q;
  logic               mem_read_q;
  logic               mem_write_q;
  logic [9:0]         mem_addr_q;
  logic [31:0]        mem_wdata_q;

  // Data and tags carry no reset: a line is only trusted through valid_q.
  logic [31:0]        data_q [LINES][WORDS];
  logic [TAG_W-1:0]   tag_q  [LINES];

  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_idx;
  logic [OFF_W-1:0]   req_word;
  logic               hit;
  logic               last_word;
  logic               unused_addr_bits;

  assign req_tag   = addr_q[9 -: TAG_W];
  assign req_idx   = addr_q[OFF_W+2 +: IDX_W];
  assign req_word  = addr_q[2 +: OFF_W];
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign last_word = (cnt_q == OFF_W'(WORDS - 1));

  // Byte-within-word bits never select anything.
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_done  = cpu_done_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      valid_q     <= '0;
      dirty_q     <= '0;
      cpu_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      cpu_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Skipping the cycle that shows cpu_done keeps a still-held
          // request from being accepted twice.
          if (!cpu_done_q && (cpu_read || cpu_write)) begin
            addr_q  <= cpu_addr[9:2];
            wdata_q <= cpu_wdata;
            wr_q    <= !cpu_read;
            state_q <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          cnt_q <= '0;
          if (hit) begin
            if (wr_q) begin
              dirty_q[req_idx] <= 1'b1;
            end else begin
              cpu_rdata_q <= data_q[req_idx][req_word];
            end
            cpu_done_q <= 1'b1;
            state_q    <= S_IDLE;
          end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_q <= S_WRITEBACK;
          end else begin
            state_q <= S_ALLOCATE;
          end
        end
        S_WRITEBACK: begin
          // Request low means either first word or the one-cycle gap after
          // the previous word; both lead straight into the next request.
          if (!mem_write_q) begin
            mem_write_q <= 1'b1;
            mem_addr_q  <= {tag_q[req_idx], req_idx, cnt_q, 2'b00};
            mem_wdata_q <= data_q[req_idx][cnt_q];
          end else if (mem_done) begin
            mem_write_q <= 1'b0;
            cnt_q       <= cnt_q + 1'b1;
            if (last_word) begin
              cnt_q   <= '0;
              state_q <= S_ALLOCATE;
            end
          end
        end
        S_ALLOCATE: begin
          if (!mem_read_q) begin
            mem_read_q <= 1'b1;
            mem_addr_q <= {req_tag, req_idx, cnt_q, 2'b00};
          end else if (mem_done) begin
            mem_read_q <= 1'b0;
            cnt_q      <= cnt_q + 1'b1;
            if (last_word) begin
              cnt_q            <= '0;
              valid_q[req_idx] <= 1'b1;
              dirty_q[req_idx] <= 1'b0;
              state_q          <= S_COMPARE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Array writes: refill words as they arrive (tag with the last one), and
  // store hits once the line is resident.
  always_ff @(posedge clock) begin
    if (state_q == S_ALLOCATE && mem_read_q && mem_done) begin
      data_q[req_idx][cnt_q] <= mem_rdata;
      if (last_word) begin
        tag_q[req_idx] <= req_tag;
      end
    end else if (state_q == S_COMPARE && hit && wr_q) begin
      data_q[req_idx][req_word] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dm_cache_controller.sv
// tb/tb_dm_cache_controller.sv - directed self-checking bench for dm_cache_controller
module tb_dm_cache_controller;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_read, cpu_write;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        mem_read, mem_write;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] model_rdata;
  logic        model_done;
  logic        spurious_done;
  logic        mem_done;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [256];
  logic        log_we   [64];
  logic [9:0]  log_addr [64];
  logic [31:0] log_data [64];
  int          log_n;
  int          lat_cnt;
  int          proto_err;
  int          done_pulses;
  logic        prev_req;
  logic [9:0]  prev_addr;

  assign mem_done = model_done | spurious_done;

  always #5 clk = ~clk;

  dm_cache_controller #(.LINES(4), .WORDS(4)) dut (
    .clock     (clk),
    .reset     (rst),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (model_rdata),
    .mem_done  (mem_done)
  );

  // Main memory model plus handshake monitor, all on the falling edge.
  initial begin
    model_done  = 1'b0;
    model_rdata = '0;
    lat_cnt     = 0;
    prev_req    = 1'b0;
    prev_addr   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_done = 1'b0;
        lat_cnt    = 0;
        prev_req   = 1'b0;
      end else begin
        if (cpu_done) done_pulses++;
        if (mem_read && mem_write) proto_err++;
        if (prev_req && (mem_read || mem_write) && mem_addr !== prev_addr) proto_err++;
        if (prev_req && !(mem_read || mem_write) && !model_done) proto_err++;
        prev_req  = mem_read | mem_write;
        prev_addr = mem_addr;
        if (model_done) begin
          model_done = 1'b0;
          lat_cnt    = 0;
        end else if (mem_read || mem_write) begin
          if (lat_cnt == LAT - 1) begin
            model_done = 1'b1;
            if (log_n < 64) begin
              log_we[log_n]   = mem_write;
              log_addr[log_n] = mem_addr;
              log_data[log_n] = mem_write ? mem_wdata : mem[mem_addr[9:2]];
              log_n++;
            end
            if (mem_write) mem[mem_addr[9:2]] = mem_wdata;
            else           model_rdata = mem[mem_addr[9:2]];
          end else begin
            lat_cnt++;
          end
        end
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [9:0] a,
                        input logic [31:0] wd, output logic [31:0] rdata,
                        output int cyc, output bit ok);
    @(negedge clk);
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = a;
    cpu_wdata = wd;
    cyc   = 0;
    ok    = 1'b0;
    rdata = '0;
    while (cyc < 500 && !ok) begin
      @(negedge clk);
      cyc++;
      if (cpu_done) begin
        ok    = 1'b1;
        rdata = cpu_rdata;
      end
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    if (!ok) $display("FAIL access_timeout addr=%h got no cpu_done within 500 cycles", a);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL reset_cpu_rdata got=%h exp=0", cpu_rdata); end
    total++; if (cpu_done !== 1'b0) begin bad++; $display("FAIL reset_cpu_done got=%b exp=0", cpu_done); end
    total++; if ({mem_read, mem_write} !== 2'b00) begin bad++; $display("FAIL reset_mem_req got=%b exp=00", {mem_read, mem_write}); end
    total++; if (mem_addr !== 10'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_cold_read_miss;
    logic [31:0] rd; int cyc; bit ok; int p0; logic [9:0] e;
    log_n = 0;
    p0 = done_pulses;
    access(1'b1, 1'b0, 10'h040, 32'h0, rd, cyc, ok);
    total++; if (!ok) bad++;
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL cold_rdata got=%h exp=0", rd); end
    total++; if (log_n !== 4) begin bad++; $display("FAIL cold_xfer_count got=%0d exp=4", log_n); end
    for (int i = 0; i < 4; i++) begin
      e = 10'h040 + 10'(4 * i);
      total++;
      if ({log_we[i], log_addr[i]} !== {1'b0, e}) begin
        bad++; $display("FAIL cold_xfer%0d got we=%b addr=%h exp we=0 addr=%h", i, log_we[i], log_addr[i], e);
      end
    end
    repeat (3) @(negedge clk);
    total++; if (done_pulses - p0 !== 1) begin bad++; $display("FAIL cold_done_pulses got=%0d exp=1", done_pulses - p0); end
  endtask

  task automatic test_write_then_read_hit;
    logic [31:0] rd; int cyc; bit ok;
    access(1'b0, 1'b1, 10'h044, 32'hDEADBEEF, rd, cyc, ok);
    total++; if (!ok) bad++;
    log_n = 0;
    access(1'b1, 1'b0, 10'h044, 32'h0, rd, cyc, ok);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL hit_rdata got=%h exp=deadbeef", rd); end
    total++; if (cyc !== 2) begin bad++; $display("FAIL hit_latency got=%0d exp=2", cyc); end
    total++; if (log_n !== 0) begin bad++; $display("FAIL hit_mem_traffic got=%0d exp=0", log_n); end
  endtask

  task automatic test_dirty_eviction;
    logic [31:0] rd; int cyc; bit ok; logic [9:0] e; int nw;
    log_n = 0;
    access(1'b1, 1'b0, 10'h144, 32'h0, rd, cyc, ok);
    total++; if (log_n !== 8) begin bad++; $display("FAIL evict_xfer_count got=%0d exp=8", log_n); end
    for (int i = 0; i < 8; i++) begin
      e = (i < 4) ? 10'h040 + 10'(4 * i) : 10'h140 + 10'(4 * (i - 4));
      total++;
      if ({log_we[i], log_addr[i]} !== {(i < 4), e}) begin
        bad++; $display("FAIL evict_xfer%0d got we=%b addr=%h exp we=%b addr=%h", i, log_we[i], log_addr[i], (i < 4), e);
      end
    end
    total++; if (log_data[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL evict_wb_data got=%h exp=deadbeef", log_data[1]); end
    total++; if (log_data[0] !== 32'h0) begin bad++; $display("FAIL evict_wb_word0 got=%h exp=0", log_data[0]); end
    total++; if (rd !== 32'hA5A50144) begin bad++; $display("FAIL evict_rdata got=%h exp=a5a50144", rd); end
    log_n = 0;
    access(1'b1, 1'b0, 10'h044, 32'h0, rd, cyc, ok);
    nw = 0;
    for (int i = 0; i < log_n; i++) if (log_we[i]) nw++;
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL refill_rdata got=%h exp=deadbeef", rd); end
    total++; if (log_n !== 4 || nw !== 0) begin bad++; $display("FAIL refill_xfers got=%0d writes=%0d exp=4 writes=0", log_n, nw); end
  endtask

  task automatic test_clean_eviction;
    logic [31:0] rd; int cyc; bit ok; int nw;
    log_n = 0;
    access(1'b1, 1'b0, 10'h080, 32'h0, rd, cyc, ok);
    total++; if (rd !== 32'hCAFE0080) begin bad++; $display("FAIL clean_rdata_080 got=%h exp=cafe0080", rd); end
    access(1'b1, 1'b0, 10'h180, 32'h0, rd, cyc, ok);
    total++; if (rd !== 32'hBEEF0180) begin bad++; $display("FAIL clean_rdata_180 got=%h exp=beef0180", rd); end
    nw = 0;
    for (int i = 0; i < log_n; i++) if (log_we[i]) nw++;
    total++; if (log_n !== 8 || nw !== 0) begin bad++; $display("FAIL clean_xfers got=%0d writes=%0d exp=8 writes=0", log_n, nw); end
  endtask

  task automatic test_simultaneous;
    logic [31:0] rd; int cyc; bit ok; int nw;
    access(1'b1, 1'b0, 10'h044, 32'h0, rd, cyc, ok);
    log_n = 0;
    access(1'b1, 1'b1, 10'h044, 32'h12345678, rd, cyc, ok);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL simul_rdata got=%h exp=deadbeef", rd); end
    total++; if (cyc !== 2 || log_n !== 0) begin bad++; $display("FAIL simul_hit got cyc=%0d xfers=%0d exp cyc=2 xfers=0", cyc, log_n); end
    log_n = 0;
    access(1'b1, 1'b0, 10'h144, 32'h0, rd, cyc, ok);
    nw = 0;
    for (int i = 0; i < log_n; i++) if (log_we[i]) nw++;
    total++; if (nw !== 0) begin bad++; $display("FAIL simul_line_clean got writes=%0d exp=0", nw); end
    total++; if (rd !== 32'hA5A50144) begin bad++; $display("FAIL simul_next_rdata got=%h exp=a5a50144", rd); end
  endtask

  task automatic test_spurious_done;
    logic [31:0] rd; int cyc; bit ok;
    @(negedge clk) spurious_done = 1'b1;
    @(negedge clk) spurious_done = 1'b0;
    @(negedge clk);
    total++; if ({mem_read, mem_write, cpu_done} !== 3'b000) begin bad++; $display("FAIL spurious_outputs got=%b exp=000", {mem_read, mem_write, cpu_done}); end
    log_n = 0;
    access(1'b1, 1'b0, 10'h148, 32'h0, rd, cyc, ok);
    total++; if (cyc !== 2 || log_n !== 0) begin bad++; $display("FAIL spurious_hit got cyc=%0d xfers=%0d exp cyc=2 xfers=0", cyc, log_n); end
  endtask

  task automatic test_reset_mid_allocate;
    logic [31:0] rd; int cyc; bit ok; int n; logic [9:0] e;
    access(1'b1, 1'b0, 10'h050, 32'h0, rd, cyc, ok);
    log_n = 0;
    @(negedge clk);
    cpu_read = 1'b1;
    cpu_addr = 10'h0C0;
    n = 0;
    while (log_n < 2 && n < 500) begin @(negedge clk); n++; end
    total++; if (log_n < 2) begin bad++; $display("FAIL midreset_wait got xfers=%0d exp=2", log_n); end
    @(posedge clk); #1 rst = 1'b1;
    #1;
    total++;
    if ({cpu_rdata, cpu_done, mem_read, mem_write, mem_addr, mem_wdata} !== 76'h0) begin
      bad++; $display("FAIL midreset_outputs got rdata=%h done=%b rd=%b wr=%b addr=%h wdata=%h exp all 0",
                      cpu_rdata, cpu_done, mem_read, mem_write, mem_addr, mem_wdata);
    end
    cpu_read = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    log_n = 0;
    access(1'b1, 1'b0, 10'h0C0, 32'h0, rd, cyc, ok);
    total++; if (log_n !== 4) begin bad++; $display("FAIL midreset_refill_count got=%0d exp=4", log_n); end
    for (int i = 0; i < 4; i++) begin
      e = 10'h0C0 + 10'(4 * i);
      total++;
      if ({log_we[i], log_addr[i]} !== {1'b0, e}) begin
        bad++; $display("FAIL midreset_xfer%0d got we=%b addr=%h exp we=0 addr=%h", i, log_we[i], log_addr[i], e);
      end
    end
    total++; if (rd !== 32'h0C0C0C00) begin bad++; $display("FAIL midreset_rdata got=%h exp=0c0c0c00", rd); end
    log_n = 0;
    access(1'b1, 1'b0, 10'h050, 32'h0, rd, cyc, ok);
    total++; if (log_n !== 4) begin bad++; $display("FAIL midreset_line1_invalid got xfers=%0d exp=4", log_n); end
  endtask

  task automatic test_protocol;
    total++; if (proto_err !== 0) begin bad++; $display("FAIL mem_handshake got violations=%0d exp=0", proto_err); end
  endtask

  initial begin
    rst           = 1'b1;
    cpu_read      = 1'b0;
    cpu_write     = 1'b0;
    cpu_addr      = '0;
    cpu_wdata     = '0;
    spurious_done = 1'b0;
    log_n         = 0;
    proto_err     = 0;
    done_pulses   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[10'h144 >> 2] = 32'hA5A50144;
    mem[10'h080 >> 2] = 32'hCAFE0080;
    mem[10'h180 >> 2] = 32'hBEEF0180;
    mem[10'h0C0 >> 2] = 32'h0C0C0C00;

    test_reset;
    test_cold_read_miss;
    test_write_then_read_hit;
    test_dirty_eviction;
    test_clean_eviction;
    test_simultaneous;
    test_spurious_done;
    test_reset_mid_allocate;
    test_protocol;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
